// File: rtl/ntt_bank_pkg.sv
// Shared types for the NTT bank reader: FSM states, coefficient widths and the even/odd pair word.
package ntt_bank_pkg;

    localparam int COEFF_W = 54;
    localparam int BANK_AW = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } reader_state_t;

    // Packed so that {bank1, bank0} maps directly onto {odd, even}.
    typedef struct packed {
        logic [COEFF_W-1:0] odd;
        logic [COEFF_W-1:0] even;
    } coeff_pair_t;

endpackage

// File: rtl/ntt_pair_fifo.sv
// Small synchronous FIFO of even/odd coefficient pairs; exposes its occupancy for credit checking.
module ntt_pair_fifo
    import ntt_bank_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  coeff_pair_t   i_push_data,
    input  logic          i_pop,
    output coeff_pair_t   o_head,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    coeff_pair_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap explicitly so a non-power-of-two depth still works.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/ntt_bank_reader.sv
// Streams an interleaved even/odd NTT bank pair out in natural order, one coefficient per beat.
// Optional sticky modulus range check is enabled by defining NTT_BANK_READER_RANGE_CHECK_EN.
module ntt_bank_reader
    import ntt_bank_pkg::*;
#(
    parameter int N          = 8192,
    parameter int LOGN       = 13,
    parameter int LOGQ       = COEFF_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic [LOGN-2:0] o_bank_rd_addr,
    output logic            o_bank_rd_en,
    input  logic [LOGQ-1:0] i_bank0_rd_data,
    input  logic [LOGQ-1:0] i_bank1_rd_data,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [LOGQ-1:0] o_out_data,
    output logic [LOGN-1:0] o_out_index,
    output logic            o_out_last
`ifdef NTT_BANK_READER_RANGE_CHECK_EN
    ,
    input  logic [LOGQ-1:0] i_modulus,
    input  logic            i_clr_err,
    output logic            o_range_err
`endif
);

    localparam int              CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [LOGN-2:0] ADDR_LAST = (LOGN-1)'(N / 2 - 1);
    localparam logic [LOGN-1:0] IDX_LAST  = LOGN'(N - 1);

    reader_state_t   r_state;
    reader_state_t   w_next_state;
    logic [LOGN-2:0] r_addr;
    logic [LOGN-1:0] r_idx;
    logic [RD_LAT-1:0] r_vld;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    coeff_pair_t     w_head;
    coeff_pair_t     w_push_pair;
    int              w_inflight;
    logic            w_rd_en;
    logic            w_last_issue;
    logic            w_accept;
    logic            w_fire;
    logic            w_pop;

    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_inflight = w_inflight + int'(r_vld[k]);
        end
    end

    // Reads are only issued when the FIFO can absorb every read already in the bank pipeline.
    assign w_rd_en      = (r_state == RUN) && ((int'(w_fifo_count) + w_inflight) < FIFO_DEPTH);
    assign w_last_issue = w_rd_en && (r_addr == ADDR_LAST);
    assign w_accept     = (r_state == IDLE) && i_start;
    assign w_fire       = o_out_valid && i_out_ready;
    assign w_pop        = w_fire && r_idx[0];
    assign w_push_pair  = {i_bank1_rd_data, i_bank0_rd_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (w_last_issue) w_next_state = DRAIN;
            DRAIN:   if (w_fire && o_out_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_idx  <= '0;
            r_vld  <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= '0;
            end else if (w_rd_en && !w_last_issue) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_accept || (r_state == DONE)) begin
                r_idx <= '0;
            end else if (w_fire) begin
                r_idx <= r_idx + 1'b1;
            end
            r_vld[0] <= w_rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    ntt_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_vld[RD_LAT-1]),
        .i_push_data (w_push_pair),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Even half of the head pair goes first; the pair is released on the odd handshake.
    always_comb begin
        o_out_data = '0;
        if (o_out_valid) begin
            o_out_data = r_idx[0] ? w_head.odd : w_head.even;
        end
    end

    assign o_out_valid    = !w_fifo_empty;
    assign o_out_index    = r_idx;
    assign o_out_last     = o_out_valid && (r_idx == IDX_LAST);
    assign o_bank_rd_en   = w_rd_en;
    assign o_bank_rd_addr = r_addr;
    assign o_busy         = (r_state == RUN) || (r_state == DRAIN);
    assign o_done         = (r_state == DONE);

`ifdef NTT_BANK_READER_RANGE_CHECK_EN
    logic r_range_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_range_err <= 1'b0;
        end else if (i_clr_err || w_accept) begin
            r_range_err <= 1'b0;
        end else if (w_fire && (o_out_data >= i_modulus)) begin
            r_range_err <= 1'b1;
        end
    end

    assign o_range_err = r_range_err;
`endif

endmodule
